// File: rtl/sad_pkg.sv
// -----------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD trigger path. The state encodings are
// exported as plain localparams so the SAD register map and the debug readback
// decode the sequencer state with the same values the FSM uses.
// -----------------------------------------------------------------------------
package sad_pkg;

    localparam logic [2:0] SAD_ST_IDLE    = 3'd0;
    localparam logic [2:0] SAD_ST_PRIME   = 3'd1;
    localparam logic [2:0] SAD_ST_LISTEN  = 3'd2;
    localparam logic [2:0] SAD_ST_HOLDOFF = 3'd3;
    localparam logic [2:0] SAD_ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = SAD_ST_IDLE,
        ST_PRIME   = SAD_ST_PRIME,
        ST_LISTEN  = SAD_ST_LISTEN,
        ST_HOLDOFF = SAD_ST_HOLDOFF,
        ST_DONE    = SAD_ST_DONE
    } sad_state_t;

endpackage

// File: rtl/sad_down_counter.sv
// -----------------------------------------------------------------------------
// sad_down_counter
// Loadable down-counter with a "last" flag that is high while the count is 1,
// so the owner can leave a timed state exactly on the final counted cycle.
//
// Ports
//   clk_adc     in   clock, rising edge
//   reset_n     in   asynchronous active-low reset (count clears to 0)
//   load        in   load load_value on the next edge (has priority over dec)
//   load_value  in   value to load
//   dec         in   decrement by one; holds at 0
//   last        out  count == 1
// -----------------------------------------------------------------------------
module sad_down_counter #(
    parameter int pWIDTH = 8
) (
    input  logic              clk_adc,
    input  logic              reset_n,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_value,
    input  logic              dec,
    output logic              last
);

    localparam logic [pWIDTH-1:0] ONE = pWIDTH'(1);

    logic [pWIDTH-1:0] count;

    // Load wins over decrement; the counter parks at zero rather than wrapping
    // so a stray dec after expiry cannot re-arm the last flag.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign last = (count == ONE);

endmodule

// File: rtl/sad_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// sad_trigger_sequencer
// Sits between the SAD match comparator and the capture trigger in the clk_adc
// domain. After arming it flushes the SAD window and waits pREF_SAMPLES cycles
// for the window to refill, then turns raw matches into registered one-cycle
// trigger pulses, suppresses matches for cfg_holdoff cycles after each trigger,
// and parks in DONE once cfg_num_triggers triggers have been issued.
//
// Ports
//   clk_adc           in   ADC sample clock
//   reset_n           in   asynchronous active-low reset
//   cfg_enable        in   sequencer enable (quasi-static)
//   cfg_holdoff       in   post-trigger suppression length in cycles
//   cfg_num_triggers  in   triggers per arm, 0 = unlimited
//   armed_and_ready   in   capture armed
//   sad_match         in   raw per-sample SAD match
//   sad_flush         out  one-cycle pulse on entry to PRIME
//   trigger           out  one-cycle trigger pulse (flop output)
//   busy              out  high in PRIME, LISTEN, HOLDOFF
//   done              out  high in DONE
//   trig_count        out  triggers issued since last arm
//   missed_count      out  matches suppressed in HOLDOFF since arm, saturating
// -----------------------------------------------------------------------------
module sad_trigger_sequencer
    import sad_pkg::*;
#(
    parameter int pREF_SAMPLES   = 32,
    parameter int pHOLDOFF_WIDTH = 16,
    parameter int pNTRIG_WIDTH   = 8
) (
    input  logic                      clk_adc,
    input  logic                      reset_n,
    input  logic                      cfg_enable,
    input  logic [pHOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic [pNTRIG_WIDTH-1:0]   cfg_num_triggers,
    input  logic                      armed_and_ready,
    input  logic                      sad_match,
    output logic                      sad_flush,
    output logic                      trigger,
    output logic                      busy,
    output logic                      done,
    output logic [pNTRIG_WIDTH-1:0]   trig_count,
    output logic [pNTRIG_WIDTH-1:0]   missed_count
);

    localparam int                      REF_WIDTH = $clog2(pREF_SAMPLES + 1);
    localparam logic [REF_WIDTH-1:0]    REF_LOAD  = REF_WIDTH'(pREF_SAMPLES);
    localparam logic [pNTRIG_WIDTH-1:0] NTRIG_ONE = pNTRIG_WIDTH'(1);

    sad_state_t              state;
    sad_state_t              state_next;
    logic                    go;
    logic                    trig_fire;
    logic                    flush_fire;
    logic                    miss_fire;
    logic                    prime_load;
    logic                    prime_dec;
    logic                    prime_last;
    logic                    hold_load;
    logic                    hold_dec;
    logic                    hold_last;
    logic [pNTRIG_WIDTH-1:0] trig_count_inc;

    assign go = cfg_enable & armed_and_ready;

    sad_down_counter #(
        .pWIDTH (REF_WIDTH)
    ) u_prime_counter (
        .clk_adc    (clk_adc),
        .reset_n    (reset_n),
        .load       (prime_load),
        .load_value (REF_LOAD),
        .dec        (prime_dec),
        .last       (prime_last)
    );

    sad_down_counter #(
        .pWIDTH (pHOLDOFF_WIDTH)
    ) u_holdoff_counter (
        .clk_adc    (clk_adc),
        .reset_n    (reset_n),
        .load       (hold_load),
        .load_value (cfg_holdoff),
        .dec        (hold_dec),
        .last       (hold_last)
    );

    // Value trig_count takes if this cycle triggers. Unlimited mode wraps; a
    // limited run saturates so a count limit lowered mid-run cannot roll over.
    always_comb begin
        trig_count_inc = trig_count + NTRIG_ONE;
        if ((cfg_num_triggers != '0) && (trig_count == '1)) begin
            trig_count_inc = trig_count;
        end
    end

    // State register.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes. Losing go sends every state to IDLE
    // and masks all strobes, so an abort beats a simultaneous match and leaves
    // both counters untouched. The holdoff length and count limit are read
    // only at the moment of a trigger, which is when a config change lands.
    always_comb begin
        state_next = state;
        trig_fire  = 1'b0;
        flush_fire = 1'b0;
        miss_fire  = 1'b0;
        prime_load = 1'b0;
        prime_dec  = 1'b0;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        if (!go) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_PRIME;
                    flush_fire = 1'b1;
                    prime_load = 1'b1;
                end
                ST_PRIME: begin
                    prime_dec = 1'b1;
                    if (prime_last) begin
                        state_next = ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    if (sad_match) begin
                        trig_fire = 1'b1;
                        if ((cfg_num_triggers != '0) && (trig_count_inc == cfg_num_triggers)) begin
                            state_next = ST_DONE;
                        end else if (cfg_holdoff != '0) begin
                            state_next = ST_HOLDOFF;
                            hold_load  = 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    hold_dec  = 1'b1;
                    miss_fire = sad_match;
                    if (hold_last) begin
                        state_next = ST_LISTEN;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Trigger and flush are registered so they can never glitch, and so the
    // trigger lands exactly one clock after the accepted match.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            trigger   <= 1'b0;
            sad_flush <= 1'b0;
        end else begin
            trigger   <= trig_fire;
            sad_flush <= flush_fire;
        end
    end

    // Per-arm statistics: cleared on the arming edge, otherwise stepped by the
    // strobes above. missed_count sticks at all-ones.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            trig_count   <= '0;
            missed_count <= '0;
        end else if (flush_fire) begin
            trig_count   <= '0;
            missed_count <= '0;
        end else begin
            if (trig_fire) begin
                trig_count <= trig_count_inc;
            end
            if (miss_fire && (missed_count != '1)) begin
                missed_count <= missed_count + NTRIG_ONE;
            end
        end
    end

    assign busy = (state == ST_PRIME) || (state == ST_LISTEN) || (state == ST_HOLDOFF);
    assign done = (state == ST_DONE);

endmodule
